// File: rtl/memory_dp.sv
// Dual-port data memory: port A read/write, port B read-only, both req/ack with one-cycle read latency.
// After reset the whole array is cleared. Define MEM_PARITY_EN to add per-word even parity with error injection.
module memory_dp #(
    parameter int unsigned             ADDR_WIDTH  = 8,
    parameter int unsigned             DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE = '0,
    parameter int unsigned             B_FORWARD   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  busy
`ifdef MEM_PARITY_EN
    ,
    input  logic                  par_inj,
    output logic                  a_perr,
    output logic                  b_perr
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef MEM_PARITY_EN
    localparam int unsigned MW = DATA_WIDTH + 1;
`else
    localparam int unsigned MW = DATA_WIDTH;
`endif

    typedef enum logic [0:0] {CLEAR, READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_d, a_ack_d, b_ack_d;
    logic [DATA_WIDTH-1:0] a_dout_d, b_dout_d;
    logic [MW-1:0]         mem [DEPTH];
    logic [MW-1:0]         clr_word, wr_word_c, a_rd_c, b_rd_c, mem_wdata_c;
    logic [ADDR_WIDTH-1:0] mem_waddr_c;
    logic                  mem_we_c;
`ifdef MEM_PARITY_EN
    logic                  a_perr_d, b_perr_d;

    // Stored word is {parity, data}; injection flips the parity bit
    assign clr_word  = {^CLEAR_VALUE, CLEAR_VALUE};
    assign wr_word_c = {(^a_din) ^ par_inj, a_din};
`else
    assign clr_word  = CLEAR_VALUE;
    assign wr_word_c = a_din;
`endif

    assign a_rd_c = mem[a_addr];

    // B sees the in-flight A write data on a same-address collision when forwarding is enabled
    always_comb begin
        b_rd_c = mem[b_addr];
        if ((B_FORWARD != 0) && a_req && a_we && (a_addr == b_addr)) begin
            b_rd_c = wr_word_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy    <= 1'b1;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_dout  <= '0;
            b_dout  <= '0;
`ifdef MEM_PARITY_EN
            a_perr  <= 1'b0;
            b_perr  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            a_ack   <= a_ack_d;
            b_ack   <= b_ack_d;
            a_dout  <= a_dout_d;
            b_dout  <= b_dout_d;
`ifdef MEM_PARITY_EN
            a_perr  <= a_perr_d;
            b_perr  <= b_perr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = 1'b0;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_dout_d    = a_dout;
        b_dout_d    = b_dout;
        mem_we_c    = 1'b0;
        mem_waddr_c = a_addr;
        mem_wdata_c = wr_word_c;
`ifdef MEM_PARITY_EN
        a_perr_d    = a_perr;
        b_perr_d    = b_perr;
`endif
        case (state_q)
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q;
                mem_wdata_c = clr_word;
                // Terminal count detected explicitly so the counter never wraps
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    busy_d = 1'b1;
                    cnt_d  = ADDR_WIDTH'(cnt_q + 1'b1);
                end
            end
            READY: begin
                if (a_req) begin
                    a_ack_d = 1'b1;
                    if (a_we) begin
                        mem_we_c = 1'b1;
                    end else begin
                        a_dout_d = a_rd_c[DATA_WIDTH-1:0];
`ifdef MEM_PARITY_EN
                        a_perr_d = ^a_rd_c;
`endif
                    end
                end
                if (b_req) begin
                    b_ack_d  = 1'b1;
                    b_dout_d = b_rd_c[DATA_WIDTH-1:0];
`ifdef MEM_PARITY_EN
                    b_perr_d = ^b_rd_c;
`endif
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

endmodule

// File: tb/tb_memory_dp.sv
// Self-checking bench for memory_dp: directed scenarios plus randomized traffic against an array model.
module tb_memory_dp;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam logic [7:0]  CLR   = 8'h00;
    localparam int unsigned B_FWD = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
    logic [7:0] a_addr = '0, a_din = '0, b_addr = '0;
    logic       a_ack, b_ack, busy;
    logic [7:0] a_dout, b_dout;
`ifdef MEM_PARITY_EN
    logic       par_inj = 1'b0;
    logic       a_perr, b_perr;
    logic       ref_bad [DEPTH];
    logic       exp_a_perr = 1'b0, exp_b_perr = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [DEPTH];
    logic       ready_m = 1'b0;
    logic       exp_a_ack = 1'b0, exp_b_ack = 1'b0;
    logic [7:0] exp_a_dout = '0, exp_b_dout = '0;

    memory_dp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLEAR_VALUE(CLR),
        .B_FORWARD  (B_FWD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_req  (a_req),
        .a_we   (a_we),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_ack  (a_ack),
        .a_dout (a_dout),
        .b_req  (b_req),
        .b_addr (b_addr),
        .b_ack  (b_ack),
        .b_dout (b_dout),
        .busy   (busy)
`ifdef MEM_PARITY_EN
        ,
        .par_inj(par_inj),
        .a_perr (a_perr),
        .b_perr (b_perr)
`endif
    );

    always #5 clk = ~clk;

    // Model of a reset: array back to clear value, outputs zero, not ready
    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i] = CLR;
`ifdef MEM_PARITY_EN
            ref_bad[i] = 1'b0;
`endif
        end
        ready_m    = 1'b0;
        exp_a_ack  = 1'b0;
        exp_b_ack  = 1'b0;
        exp_a_dout = '0;
        exp_b_dout = '0;
`ifdef MEM_PARITY_EN
        exp_a_perr = 1'b0;
        exp_b_perr = 1'b0;
`endif
    endtask

    // Apply one cycle of stimulus, advance the model, return #1 after the edge
    task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                         input logic br, input logic [7:0] ba);
        @(negedge clk);
        a_req = ar; a_we = aw; a_addr = aa; a_din = ad; b_req = br; b_addr = ba;
        exp_a_ack = ready_m && ar;
        exp_b_ack = ready_m && br;
        if (ready_m && ar && !aw) begin
            exp_a_dout = ref_mem[aa];
`ifdef MEM_PARITY_EN
            exp_a_perr = ref_bad[aa];
`endif
        end
        if (ready_m && br) begin
            if (B_FWD != 0 && ar && aw && aa == ba) begin
                exp_b_dout = ad;
`ifdef MEM_PARITY_EN
                exp_b_perr = par_inj;
`endif
            end else begin
                exp_b_dout = ref_mem[ba];
`ifdef MEM_PARITY_EN
                exp_b_perr = ref_bad[ba];
`endif
            end
        end
        if (ready_m && ar && aw) begin
            ref_mem[aa] = ad;
`ifdef MEM_PARITY_EN
            ref_bad[aa] = par_inj;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        idle_inputs();
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            total++; bad++;
            $display("FAIL wait_ready: busy=%b after %0d cycles, need 0", busy, n);
        end
        ready_m = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || a_ack !== 1'b0 || b_ack !== 1'b0 || a_dout !== 8'h00 || b_dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: busy=%b a_ack=%b b_ack=%b a_dout=%h b_dout=%h, need 1 0 0 00 00",
                     busy, a_ack, b_ack, a_dout, b_dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n != int'(DEPTH)) begin
            bad++;
            $display("FAIL busy_length: busy high %0d cycles, need %0d", n, DEPTH);
        end
        ready_m = 1'b1;
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00);
        total++;
        if (a_ack !== 1'b1 || a_dout !== CLR) begin
            bad++;
            $display("FAIL first_read: a_ack=%b a_dout=%h, need 1 %h", a_ack, a_dout, CLR);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        total++;
        if (a_ack !== 1'b0 || a_dout !== CLR) begin
            bad++;
            $display("FAIL ack_pulse: a_ack=%b a_dout=%h, need 0 %h", a_ack, a_dout, CLR);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'(i), vals[i], 1'b0, 8'h00);
            total++;
            if (a_ack !== 1'b1 || a_dout !== CLR) begin
                bad++;
                $display("FAIL b2b_write%0d: a_ack=%b a_dout=%h, need 1 %h", i, a_ack, a_dout, CLR);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b0, 8'h00);
            total++;
            if (a_ack !== 1'b1 || a_dout !== vals[i]) begin
                bad++;
                $display("FAIL b2b_read%0d: a_ack=%b a_dout=%h, need 1 %h", i, a_ack, a_dout, vals[i]);
            end
        end
        // Read-after-write on consecutive cycles
        drive(1'b1, 1'b1, 8'h20, 8'h9C, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00);
        total++;
        if (a_ack !== 1'b1 || a_dout !== 8'h9C) begin
            bad++;
            $display("FAIL raw: a_ack=%b a_dout=%h, need 1 9c", a_ack, a_dout);
        end
        idle_inputs();
    endtask

    task automatic test_busy_drop();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'h05, 8'h33, 1'b1, 8'h05);
            total++;
            if (a_ack !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_drop%0d: a_ack=%b b_ack=%b busy=%b, need 0 0 1", i, a_ack, b_ack, busy);
            end
        end
        wait_ready();
        drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00);
        total++;
        if (a_ack !== 1'b1 || a_dout !== CLR) begin
            bad++;
            $display("FAIL busy_drop_read: a_ack=%b a_dout=%h, need 1 %h", a_ack, a_dout, CLR);
        end
    endtask

    task automatic test_collision();
        logic [7:0] need;
        need = (B_FWD != 0) ? 8'h77 : 8'h11;
        drive(1'b1, 1'b1, 8'h40, 8'h11, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h40, 8'h77, 1'b1, 8'h40);
        total++;
        if (a_ack !== 1'b1 || b_ack !== 1'b1 || b_dout !== need) begin
            bad++;
            $display("FAIL collision: a_ack=%b b_ack=%b b_dout=%h, need 1 1 %h", a_ack, b_ack, b_dout, need);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40);
        total++;
        if (b_ack !== 1'b1 || b_dout !== 8'h77) begin
            bad++;
            $display("FAIL collision_after: b_ack=%b b_dout=%h, need 1 77", b_ack, b_dout);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        total++;
        if (b_ack !== 1'b0 || b_dout !== 8'h77) begin
            bad++;
            $display("FAIL b_hold: b_ack=%b b_dout=%h, need 0 77", b_ack, b_dout);
        end
    endtask

    task automatic test_random();
        logic       ar, aw, br;
        logic [7:0] aa, ad, ba;
        for (int i = 0; i < 300; i++) begin
            ar = ($urandom_range(0, 9) < 7);
            aw = $urandom_range(0, 1) == 1;
            br = ($urandom_range(0, 9) < 6);
            aa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            ba = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            ad = 8'($urandom);
            if (i == 0) begin
                ar = 1'b1; aw = 1'b0; br = 1'b1;
            end
            drive(ar, aw, aa, ad, br, ba);
            total++;
            if (a_ack !== exp_a_ack || a_dout !== exp_a_dout || b_ack !== exp_b_ack || b_dout !== exp_b_dout) begin
                bad++;
                $display("FAIL random%0d: a_ack=%b a_dout=%h b_ack=%b b_dout=%h, need %b %h %b %h", i,
                         a_ack, a_dout, b_ack, b_dout, exp_a_ack, exp_a_dout, exp_b_ack, exp_b_dout);
            end
        end
        idle_inputs();
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        par_inj = 1'b1;
        drive(1'b1, 1'b1, 8'h03, 8'h5A, 1'b0, 8'h00);
        par_inj = 1'b0;
        drive(1'b1, 1'b1, 8'h04, 8'h5A, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00);
        total++;
        if (a_ack !== 1'b1 || a_dout !== 8'h5A || a_perr !== 1'b1) begin
            bad++;
            $display("FAIL perr_a_inj: a_ack=%b a_dout=%h a_perr=%b, need 1 5a 1", a_ack, a_dout, a_perr);
        end
        drive(1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'h03);
        total++;
        if (a_perr !== 1'b0 || b_ack !== 1'b1 || b_dout !== 8'h5A || b_perr !== 1'b1) begin
            bad++;
            $display("FAIL perr_mix: a_perr=%b b_ack=%b b_dout=%h b_perr=%b, need 0 1 5a 1",
                     a_perr, b_ack, b_dout, b_perr);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 8'h80, 8'hC3, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 8'h00);
        total++;
        if (a_ack !== 1'b1 || a_dout !== 8'hC3) begin
            bad++;
            $display("FAIL mid_accept: a_ack=%b a_dout=%h, need 1 c3", a_ack, a_dout);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (a_ack !== 1'b0 || a_dout !== 8'h00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: a_ack=%b a_dout=%h busy=%b, need 0 00 1", a_ack, a_dout, busy);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        drive(1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 8'h00);
        total++;
        if (a_ack !== 1'b1 || a_dout !== CLR) begin
            bad++;
            $display("FAIL mid_reclear: a_ack=%b a_dout=%h, need 1 %h", a_ack, a_dout, CLR);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_busy_drop();
        test_collision();
        test_random();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_dp.md
Name: memory_dp

Overview:
- Next-generation parametrised data memory for the 8-bit CPU.
- Port A is read/write; port B is read-only. Both use req/ack handshakes with one-cycle read latency.
- After every reset, a hardware clear sequence writes a known value to every location.
- Sits between the CPU datapath (port A) and the instruction-fetch or debug reader (port B).

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width.
- CLEAR_VALUE, 0, value written to every word during the clear sequence (DATA_WIDTH bits).
- B_FORWARD, 1, same-cycle A-write/B-read collision policy: 1 = B gets new data, 0 = B gets old data.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  port A request, sampled each rising edge
- a_we  input  1  port A write (1) / read (0); qualified by a_req
- a_addr  input  ADDR_WIDTH  port A address
- a_din  input  DATA_WIDTH  port A write data
- a_ack  output  1  one-cycle pulse: port A request completed
- a_dout  output  DATA_WIDTH  port A read data
- b_req  input  1  port B read request
- b_addr  input  ADDR_WIDTH  port B address
- b_ack  output  1  one-cycle pulse: port B read completed
- b_dout  output  DATA_WIDTH  port B read data
- busy  output  1  high while the clear sequence runs

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clear counter=0, busy=1.
  - a_ack=0, b_ack=0, a_dout=0, b_dout=0.
  - Pending acks are discarded.
- FSM, two states:
  - CLEAR: each cycle writes CLEAR_VALUE to mem[cnt], then cnt++. The cycle that writes DEPTH-1 transitions to READY. busy is high for exactly DEPTH cycles after rst_n deasserts; busy drops on the edge entering READY.
  - READY: serves requests. Stays in READY until the next reset.
- Acceptance:
  - A request is accepted only on an edge where state=READY (busy=0) and req=1.
  - Requests seen during CLEAR are dropped: no ack, no memory effect, not queued. Masters must wait for busy=0.
- Timing:
  - A request accepted at edge N produces ack high for the cycle following edge N, i.e. it is observed at edge N+1.
  - Back-to-back requests, one per cycle per port, are supported with no bubbles.
- Port A write: mem[a_addr] <= a_din at the accepting edge; a_ack pulses; a_dout is unchanged.
- Reads (A or B): dout is updated at the accepting edge with mem[addr] and is valid while ack=1. dout holds its value until the next accepted read on that port.
- Port A read-after-write to the same address on consecutive cycles returns the new data.
- Collision (A write and B read to the same address at the same edge):
  - B_FORWARD=1: b_dout = a_din.
  - B_FORWARD=0: b_dout = old contents.
  - The memory always ends up holding a_din.
- Addresses: the full ADDR_WIDTH range is valid, so there is no out-of-range case. The clear counter is ADDR_WIDTH+1 bits wide, or the terminal condition is detected explicitly, so the counter must not wrap back to 0 and restart.
- Reset mid-operation: outputs return to reset values immediately, the in-flight request is lost, and the entire memory is re-cleared.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit.
  - Extra input par_inj (1 bit): when high on an accepted write, the stored parity bit is inverted.
  - Extra outputs a_perr and b_perr (1 bit each): updated with the corresponding read, high when stored parity mismatches the data; reset value 0.
  - The clear sequence writes correct parity.
- Undefined: no parity storage, no par_inj/a_perr/b_perr ports. Behaviour is otherwise identical.

Test Plan:
1. Release rst_n with ADDR_WIDTH=8 -> busy=1 for exactly 256 cycles, then 0. Port A read of 0x10 -> a_dout=0x00 with a_ack one cycle later.
2. Back-to-back writes A5@0x00, 5A@0x01, FF@0x02 -> a_ack high 3 consecutive cycles. Then reads of 0x00/0x01/0x02 -> a_dout A5, 5A, FF, each with its a_ack.
3. Write 0x33@0x05 while busy=1 -> no a_ack. After busy=0, read 0x05 -> 0x00.
4. mem[0x40]=0x11; same edge: A writes 0x77@0x40, B reads 0x40 -> b_dout=0x77 (B_FORWARD=1) or 0x11 (B_FORWARD=0). A subsequent B read -> 0x77 in both cases.
5. Write 0xC3@0x80. Assert rst_n low on the cycle a read of 0x80 is accepted -> a_ack=0, a_dout=0, busy=1 immediately. After the clear completes, read 0x80 -> 0x00.
6. MEM_PARITY_EN defined: write 0x5A@0x03 with par_inj=1 and 0x5A@0x04 with par_inj=0. Read 0x03 -> a_perr=1 with a_ack. Read 0x04 -> a_perr=0. B read of 0x03 -> b_perr=1.
